// File: rtl/sd_cmd_wb_initiator.sv
// Wishbone master that pushes one SD command into the controller's TX command FIFO,
// polls status for the response and reads the response bytes back from the RX FIFO.
module sd_cmd_wb_initiator #(
    parameter int RSP_SHORT_BYTES = 5,
    parameter int RSP_LONG_BYTES  = 16,
    parameter int POLL_MAX        = 1024,
    parameter int ACK_TIMEOUT     = 64
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         cmd_start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   cmd_rsp,
    output logic [2:0]   m_wb_adr_o,
    output logic [7:0]   m_wb_dat_o,
    input  logic [7:0]   m_wb_dat_i,
    output logic [3:0]   m_wb_sel_o,
    output logic         m_wb_we_o,
    output logic         m_wb_cyc_o,
    output logic         m_wb_stb_o,
    input  logic         m_wb_ack_i,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code,
    output logic [127:0] rsp_data
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [4:0] LAST_SHORT = 5'(RSP_SHORT_BYTES - 1);
    localparam logic [4:0] LAST_LONG  = 5'(RSP_LONG_BYTES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHK_TX = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_POLL   = 3'd3;
    localparam logic [2:0] S_RD     = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    logic [2:0]    state;
    logic [2:0]    idx;
    logic [4:0]    rd_cnt;
    logic [PW-1:0] poll_cnt;
    logic [AW-1:0] ack_cnt;
    logic [5:0]    lat_index;
    logic [31:0]   lat_arg;
    logic [1:0]    lat_rsp;
    logic [7:0]    wr_byte;
    logic [4:0]    last_rd;
    logic [PW-1:0] poll_next;

    assign m_wb_sel_o = 4'b0001;
    assign last_rd    = (lat_rsp == 2'b10) ? LAST_LONG : LAST_SHORT;
    assign poll_next  = poll_cnt + 1'b1;

    always_comb begin
        wr_byte = lat_arg[7:0];
        case (idx)
            3'd0:    wr_byte = {2'b01, lat_index};
            3'd1:    wr_byte = lat_arg[31:24];
            3'd2:    wr_byte = lat_arg[23:16];
            3'd3:    wr_byte = lat_arg[15:8];
            default: wr_byte = lat_arg[7:0];
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            idx        <= '0;
            rd_cnt     <= '0;
            poll_cnt   <= '0;
            ack_cnt    <= '0;
            lat_index  <= '0;
            lat_arg    <= '0;
            lat_rsp    <= '0;
            m_wb_adr_o <= '0;
            m_wb_dat_o <= '0;
            m_wb_we_o  <= 1'b0;
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
            rsp_data   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (m_wb_cyc_o) begin
                // An access in flight: either it completes, or the watchdog aborts it.
                if (m_wb_ack_i) begin
                    m_wb_cyc_o <= 1'b0;
                    m_wb_stb_o <= 1'b0;
                    m_wb_we_o  <= 1'b0;
                    case (state)
                        S_CHK_TX: if (!m_wb_dat_i[0]) state <= S_WR;
                        S_WR: begin
                            if (idx == 3'd4) begin
                                poll_cnt <= '0;
                                state    <= (lat_rsp != 2'b00) ? S_POLL : S_DONE;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_CHK_TX;
                            end
                        end
                        S_POLL: begin
                            if (!m_wb_dat_i[1]) begin
                                state <= S_RD;
                            end else if (poll_next == PW'(POLL_MAX)) begin
                                err_code <= 2'b10;
                                state    <= S_ERR;
                            end else begin
                                poll_cnt <= poll_next;
                            end
                        end
                        S_RD: begin
                            rsp_data <= {rsp_data[119:0], m_wb_dat_i};
                            if (rd_cnt == last_rd) begin
                                state <= S_DONE;
                            end else begin
                                rd_cnt   <= rd_cnt + 1'b1;
                                poll_cnt <= '0;
                                state    <= S_POLL;
                            end
                        end
                        default: state <= state;
                    endcase
                end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                    m_wb_cyc_o <= 1'b0;
                    m_wb_stb_o <= 1'b0;
                    m_wb_we_o  <= 1'b0;
                    err_code   <= 2'b11;
                    state      <= S_ERR;
                end else begin
                    ack_cnt <= ack_cnt + 1'b1;
                end
            end else begin
                // Bus idle: bus states launch their access here, guaranteeing an idle cycle.
                case (state)
                    S_IDLE: begin
                        if (cmd_start) begin
                            if (cmd_rsp == 2'b11) begin
                                err_code <= 2'b01;
                                state    <= S_ERR;
                            end else begin
                                lat_index <= cmd_index;
                                lat_arg   <= cmd_arg;
                                lat_rsp   <= cmd_rsp;
                                rsp_data  <= '0;
                                err_code  <= '0;
                                busy      <= 1'b1;
                                idx       <= '0;
                                rd_cnt    <= '0;
                                state     <= S_CHK_TX;
                            end
                        end
                    end
                    S_CHK_TX, S_POLL, S_RD, S_WR: begin
                        m_wb_cyc_o <= 1'b1;
                        m_wb_stb_o <= 1'b1;
                        ack_cnt    <= '0;
                        m_wb_we_o  <= (state == S_WR);
                        m_wb_dat_o <= (state == S_WR) ? wr_byte : 8'h00;
                        m_wb_adr_o <= (state == S_WR) ? 3'd0 : (state == S_RD) ? 3'd1 : 3'd4;
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    S_ERR: begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_wb_initiator.sv
// Directed bench for sd_cmd_wb_initiator with a behavioural FIFO-controller slave.
module tb_sd_cmd_wb_initiator;

    logic         clk = 1'b0;
    logic         wb_rst_i;
    logic         cmd_start;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   cmd_rsp;
    logic [2:0]   adr;
    logic [7:0]   dat_o;
    logic [7:0]   dat_i;
    logic [3:0]   sel;
    logic         we, cyc, stb, ack;
    logic         busy, done, err;
    logic [1:0]   err_code;
    logic [127:0] rsp_data;

    int compared = 0;
    int mismatched = 0;

    // slave model state
    int       ack_lat = 2;
    bit       ack_en = 1;
    int       tx_full_cnt = 0;
    bit       rx_stuck = 0;
    bit       last_full = 0;
    int       wcnt = 0;
    logic [7:0] wr_log[$];
    logic [7:0] rsp_q[$];
    int       st_cnt, rd1_cnt, poll_rd, wr_while_full, prot_err = 0;
    logic [2:0] s_adr;
    logic       s_we;
    logic [7:0] s_dat;

    // run_cmd results
    bit got_done, got_err, busy_after;
    int stb_hi;

    always #5 clk = ~clk;

    sd_cmd_wb_initiator #(.RSP_SHORT_BYTES(5), .RSP_LONG_BYTES(16), .POLL_MAX(8), .ACK_TIMEOUT(64)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .cmd_rsp(cmd_rsp), .m_wb_adr_o(adr), .m_wb_dat_o(dat_o),
        .m_wb_dat_i(dat_i), .m_wb_sel_o(sel), .m_wb_we_o(we), .m_wb_cyc_o(cyc),
        .m_wb_stb_o(stb), .m_wb_ack_i(ack), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .rsp_data(rsp_data)
    );

    // Slave: registered ack ack_lat cycles after strobe, driven on the falling edge.
    always @(negedge clk) begin
        if (wb_rst_i) begin
            ack = 1'b0;
            wcnt = 0;
        end else if (ack) begin
            ack = 1'b0;
            wcnt = 0;
            if (cyc) prot_err++;
        end else if (cyc && stb) begin
            if (wcnt == 0) {s_adr, s_we, s_dat} = {adr, we, dat_o};
            else if ({s_adr, s_we, s_dat} !== {adr, we, dat_o}) prot_err++;
            wcnt++;
            if (ack_en && wcnt >= ack_lat) begin
                ack = 1'b1;
                if (we && adr == 3'd0) begin
                    if (last_full) wr_while_full++;
                    wr_log.push_back(dat_o);
                end else if (!we && adr == 3'd4) begin
                    st_cnt++;
                    last_full = (tx_full_cnt > 0);
                    if (last_full) tx_full_cnt--;
                    if (wr_log.size() == 5) poll_rd++;
                    dat_i = {6'b0, (rx_stuck || rsp_q.size() == 0), last_full};
                end else if (!we && adr == 3'd1) begin
                    rd1_cnt++;
                    dat_i = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hEE;
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    function automatic logic [39:0] wr_pack();
        logic [39:0] v = '0;
        for (int i = 0; i < wr_log.size() && i < 5; i++) v = {v[31:0], wr_log[i]};
        return v;
    endfunction

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rsp);
        int n = 0;
        wr_log.delete();
        st_cnt = 0; rd1_cnt = 0; poll_rd = 0; wr_while_full = 0; last_full = 0;
        got_done = 0; got_err = 0; stb_hi = 0;
        cmd_index = idx; cmd_arg = arg; cmd_rsp = rsp; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        busy_after = busy;
        while (n < 5000) begin
            if (stb) stb_hi++;
            if (done) got_done = 1;
            if (err) got_err = 1;
            if (got_done || got_err) break;
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 5000) begin
            mismatched++;
            $display("FAIL completion idx=%0d no done/err within 5000 cycles", idx);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        wb_rst_i = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_rsp = '0;
        ack = 1'b0; dat_i = '0;
        repeat (3) @(negedge clk);
        compared++;
        if ({cyc, stb, we, adr, dat_o, busy, done, err, err_code} !== '0 || rsp_data !== '0 || sel !== 4'b0001) begin
            mismatched++;
            $display("FAIL reset_outputs got cyc=%b stb=%b busy=%b err_code=%b sel=%b exp all zero, sel=0001",
                     cyc, stb, busy, err_code, sel);
        end
        wb_rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd0_no_rsp;
        run_cmd(6'd0, 32'h0, 2'b00);
        compared++;
        if (wr_log.size() != 5 || wr_pack() !== 40'h4000000000) begin
            mismatched++;
            $display("FAIL t1_wr_bytes got n=%0d %h exp n=5 4000000000", wr_log.size(), wr_pack());
        end
        compared++;
        if (st_cnt != 5 || rd1_cnt != 0) begin
            mismatched++;
            $display("FAIL t1_reads got status=%0d rx=%0d exp 5/0", st_cnt, rd1_cnt);
        end
        compared++;
        if (!got_done || got_err || !busy_after || busy) begin
            mismatched++;
            $display("FAIL t1_handshake got done=%b err=%b busy_after=%b busy=%b exp 1/0/1/0",
                     got_done, got_err, busy_after, busy);
        end
    endtask

    task automatic test_short_rsp;
        rsp_q = '{8'h11, 8'h00, 8'h00, 8'h09, 8'h00};
        run_cmd(6'd17, 32'h0000_1234, 2'b01);
        compared++;
        if (wr_pack() !== 40'h5100001234) begin
            mismatched++;
            $display("FAIL t2_wr_bytes got %h exp 5100001234", wr_pack());
        end
        compared++;
        if (rsp_data !== 128'h11_0000_0900 || rd1_cnt != 5) begin
            mismatched++;
            $display("FAIL t2_rsp_data got %h rx=%0d exp 1100000900 rx=5", rsp_data, rd1_cnt);
        end
        compared++;
        if (!got_done || err_code !== 2'b00) begin
            mismatched++;
            $display("FAIL t2_status got done=%b err_code=%b exp 1/00", got_done, err_code);
        end
        repeat (4) @(negedge clk);
        compared++;
        if (rsp_data !== 128'h11_0000_0900) begin
            mismatched++;
            $display("FAIL t2_rsp_hold got %h exp 1100000900", rsp_data);
        end
    endtask

    task automatic test_long_rsp;
        for (int i = 1; i <= 16; i++) rsp_q.push_back(8'(i));
        run_cmd(6'd2, 32'h0, 2'b10);
        compared++;
        if (rsp_data !== 128'h0102030405060708090a0b0c0d0e0f10 || rd1_cnt != 16) begin
            mismatched++;
            $display("FAIL t3_long_rsp got %h rx=%0d exp 0102..0f10 rx=16", rsp_data, rd1_cnt);
        end
        compared++;
        if (wr_pack() !== 40'h4200000000 || !got_done) begin
            mismatched++;
            $display("FAIL t3_wr_done got %h done=%b exp 4200000000 done=1", wr_pack(), got_done);
        end
    endtask

    task automatic test_tx_full;
        tx_full_cnt = 20;
        run_cmd(6'd0, 32'h0, 2'b00);
        compared++;
        if (wr_while_full != 0 || st_cnt != 25 || wr_log.size() != 5) begin
            mismatched++;
            $display("FAIL t4_tx_full got early_wr=%0d status=%0d wr=%0d exp 0/25/5",
                     wr_while_full, st_cnt, wr_log.size());
        end
        compared++;
        if (!got_done || got_err) begin
            mismatched++;
            $display("FAIL t4_done got done=%b err=%b exp 1/0", got_done, got_err);
        end
    endtask

    task automatic test_poll_timeout;
        rx_stuck = 1;
        run_cmd(6'd13, 32'h0001_0000, 2'b01);
        rx_stuck = 0;
        compared++;
        if (poll_rd != 8 || rd1_cnt != 0) begin
            mismatched++;
            $display("FAIL t5_poll_count got polls=%0d rx=%0d exp 8/0", poll_rd, rd1_cnt);
        end
        compared++;
        if (!got_err || got_done || err_code !== 2'b10 || busy) begin
            mismatched++;
            $display("FAIL t5_poll_err got err=%b done=%b code=%b busy=%b exp 1/0/10/0",
                     got_err, got_done, err_code, busy);
        end
    endtask

    task automatic test_ack_timeout;
        ack_en = 0;
        run_cmd(6'd0, 32'h0, 2'b00);
        ack_en = 1;
        compared++;
        if (stb_hi != 64) begin
            mismatched++;
            $display("FAIL t6_stb_cycles got %0d exp 64", stb_hi);
        end
        compared++;
        if (!got_err || err_code !== 2'b11 || busy || stb) begin
            mismatched++;
            $display("FAIL t6_ack_err got err=%b code=%b busy=%b stb=%b exp 1/11/0/0",
                     got_err, err_code, busy, stb);
        end
    endtask

    task automatic test_illegal_rsp;
        run_cmd(6'd8, 32'h1AA, 2'b11);
        compared++;
        if (!got_err || err_code !== 2'b01 || busy_after || stb_hi != 0) begin
            mismatched++;
            $display("FAIL illegal_rsp got err=%b code=%b busy=%b stb_cycles=%0d exp 1/01/0/0",
                     got_err, err_code, busy_after, stb_hi);
        end
    endtask

    task automatic test_reset_mid_wr;
        int n = 0;
        wr_log.delete();
        cmd_index = 6'd0; cmd_arg = 32'h0; cmd_rsp = 2'b00; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        while (!(cyc && we) && n < 500) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 500) begin
            mismatched++;
            $display("FAIL rst_reach_wr got no write access within 500 cycles");
        end
        #1 wb_rst_i = 1'b1;
        #1;
        compared++;
        if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_async got cyc=%b stb=%b busy=%b exp 0/0/0", cyc, stb, busy);
        end
        @(negedge clk);
        wb_rst_i = 1'b0;
        @(negedge clk);
        run_cmd(6'd0, 32'h0, 2'b00);
        compared++;
        if (!got_done || got_err || wr_pack() !== 40'h4000000000 || err_code !== 2'b00) begin
            mismatched++;
            $display("FAIL rst_recover got done=%b err=%b wr=%h code=%b exp 1/0/4000000000/00",
                     got_done, got_err, wr_pack(), err_code);
        end
    endtask

    task automatic test_protocol;
        compared++;
        if (prot_err != 0) begin
            mismatched++;
            $display("FAIL bus_protocol got %0d violations exp 0", prot_err);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0_no_rsp();
        test_short_rsp();
        test_long_rsp();
        test_tx_full();
        test_poll_timeout();
        test_ack_timeout();
        test_illegal_rsp();
        test_reset_mid_wr();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sd_cmd_wb_initiator.md
Name: sd_cmd_wb_initiator

Overview:
Wishbone master that drives the SD controller's 8-bit FIFO slave register map to issue one SD command and collect its response. It writes the command bytes into the TX command FIFO, polls the status register until the response arrives in the RX command FIFO, and reads back the response bytes. It sits between a host-side sequencer (init/boot FSM) and the FIFO controller's Wishbone slave port.

Parameters:
RSP_SHORT_BYTES, 5, bytes read for a short (48-bit) response: index plus 32 bits
RSP_LONG_BYTES, 16, bytes read for a long (R2) response; must be ≤16
POLL_MAX, 1024, status reads allowed while waiting for the response before timeout
ACK_TIMEOUT, 64, cycles allowed for any single Wishbone access to be acked

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; asynchronous, active-high
cmd_start  in  1  1-cycle request; sampled only in IDLE
cmd_index  in  6  SD command index
cmd_arg  in  32  command argument
cmd_rsp  in  2  00 none, 01 short, 10 long, 11 illegal
m_wb_adr_o  out  3  slave address
m_wb_dat_o  out  8  write data
m_wb_dat_i  in  8  read data
m_wb_sel_o  out  4  byte select; constant 4'b0001
m_wb_we_o  out  1  write enable
m_wb_cyc_o  out  1  cycle
m_wb_stb_o  out  1  strobe
m_wb_ack_i  in  1  acknowledge
busy  out  1  high from the accepted start until done/err
done  out  1  1-cycle pulse on successful completion
err  out  1  1-cycle pulse on failure
err_code  out  2  01 illegal cmd_rsp, 10 poll timeout, 11 ack timeout; held until next start
rsp_data  out  128  response bytes, right-aligned, first byte read is most significant

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and rsp_data cleared. A reset mid-access drops cyc/stb asynchronously.
- Slave map: 0 TX cmd FIFO (write), 1 RX cmd FIFO (read), 4 status (read; bit0 TX full, bit1 RX empty).
- Bus access: cyc, stb, adr, we and dat are driven together and held stable until the cycle in which ack=1 is sampled. In that cycle the read data is captured, and cyc/stb drop on the next edge. At least one idle cycle separates accesses. Same-cycle ack is never assumed.
- Ack watchdog: a counter reset at each access start. Reaching ACK_TIMEOUT without ack drops cyc/stb and goes to ERR with code 11.
- States:
  - IDLE: on cmd_start with cmd_rsp=11, go to ERR with code 01. On any other cmd_start, latch the inputs, clear rsp_data and err_code, set busy, byte index=0, go to CHK_TX.
  - CHK_TX: read status. If bit0=1, repeat the read. If bit0=0, go to WR. TX-full stalls have no timeout.
  - WR: write byte[idx] to address 0. byte0={2'b01,cmd_index}; bytes 1-4 are cmd_arg[31:24] down to [7:0]. After ack: if idx=4, go to POLL if cmd_rsp≠00, else go to DONE. Otherwise idx+1 and go to CHK_TX.
  - POLL: read status and increment the poll counter. If bit1=0, go to RD. Else if the counter equals POLL_MAX, go to ERR with code 10. Else read again.
  - RD: read address 1 and shift rsp_data <= {rsp_data[119:0], dat}. After the Nth byte (N=RSP_SHORT_BYTES or RSP_LONG_BYTES), go to DONE. Otherwise go to POLL with the poll counter reset.
  - DONE: pulse done, clear busy, return to IDLE.
  - ERR: pulse err, clear busy, return to IDLE.
- cmd_start while busy is ignored; no queueing.
- rsp_data is stable from done until the next accepted start.
- The poll counter is reset at each entry to POLL from WR or RD. Its width is clog2(POLL_MAX+1).

Test Plan:
1. CMD0, arg 0, rsp=00, slave acks after 2 cycles -> writes 0x40,00,00,00,00 to address 0, each preceded by a status read; done after the 5th ack; no address-1 reads.
2. CMD17, arg 0x00001234, rsp=01, slave returns 11,00,00,09,00 -> writes 0x51,00,00,12,34; rsp_data[39:0]=0x1100000900; done=1; err_code=00.
3. rsp=10 with 16 response bytes 0x01..0x10 -> rsp_data=0x0102…10; exactly 16 address-1 reads.
4. Status bit0 held 1 for 20 reads, then 0 -> no address-0 write until bit0=0; command completes normally.
5. Status bit1 stuck at 1 with POLL_MAX=8 -> exactly 8 POLL reads, err pulse, err_code=10, busy=0.
6. Ack withheld with ACK_TIMEOUT=64 -> stb drops after 64 cycles, err_code=11. Separately, assert wb_rst_i mid-WR -> cyc/stb/busy go to 0 immediately, and the next cmd_start completes normally.
